// File: rtl/rd_seq_pkg.sv
// Shared types and constants for the read test sequencer.
// State encoding, sts_error bit meanings, default timeout.
package rd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    // sts_error[0]: bus response error from the engine
    // sts_error[1]: read data mismatch from the engine
    localparam int ERR_RESP_BIT = 0;
    localparam int ERR_DATA_BIT = 1;

    // Latched timeout after reset: 0 means no limit
    localparam logic [31:0] DEF_TIMEOUT = 32'd0;

endpackage

// File: rtl/rd_seq_timer.sv
// Per-iteration wait counter with expiry compare.
// Ports: clk, rst_n, clear, enable, limit[31:0], expired.
module rd_seq_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 32'd0;
        end else if (enable) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the limit-th enabled cycle after a clear
    assign expired = enable && !clear &&
                     (limit != 32'd0) &&
                     (cnt_q == limit - 32'd1);

endmodule

// File: rtl/rd_test_sequencer.sv
// Loops a read engine over latched parameters and collects status.
// Ports: cfg_* run setup in, latched params out, engine handshake, sts_*.
module rd_test_sequencer #(
    parameter int STOP_ON_ERROR = 1,
    parameter int CYC_WIDTH     = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic [15:0]          cfg_loop_count,
    input  logic [31:0]          cfg_timeout,
    input  logic [63:0]          cfg_source_address,
    input  logic [31:0]          cfg_rd_pattern,
    input  logic [31:0]          cfg_rd_number,
    input  logic [31:0]          cfg_rd_init_data,
    input  logic                 cfg_wrap_mode,
    input  logic [3:0]           cfg_wrap_len,
    output logic [63:0]          source_address,
    output logic [31:0]          rd_pattern,
    output logic [31:0]          rd_number,
    output logic [31:0]          rd_init_data,
    output logic                 wrap_mode,
    output logic [3:0]           wrap_len,
    output logic                 engine_start_pulse,
    input  logic                 rd_done_pulse,
    input  logic [1:0]           rd_error,
    input  logic [63:0]          rd_error_info,
    output logic                 busy,
    output logic                 done,
    output logic                 sts_timeout,
    output logic                 sts_aborted,
    output logic [1:0]           sts_error,
    output logic [63:0]          sts_err_info,
    output logic [15:0]          sts_iter,
    output logic [CYC_WIDTH-1:0] sts_cycles
);

    import rd_seq_pkg::*;

    seq_state_e state_q, state_d;

    logic [63:0]          src_q, src_d;
    logic [31:0]          pat_q, pat_d;
    logic [31:0]          num_q, num_d;
    logic [31:0]          init_q, init_d;
    logic                 wm_q, wm_d;
    logic [3:0]           wl_q, wl_d;
    logic [15:0]          loop_q, loop_d;
    logic [31:0]          tmo_q, tmo_d;
    logic [15:0]          iter_q, iter_d;
    logic [1:0]           err_q, err_d;
    logic [63:0]          info_q, info_d;
    logic                 to_q, to_d;
    logic                 ab_q, ab_d;
    logic                 pend_q, pend_d;
    logic [CYC_WIDTH-1:0] cyc_q, cyc_d;

    logic        t_clear, t_en, t_exp;
    logic [16:0] eff_loop, iter_nx;
    logic [1:0]  err_acc;
    logic        remain, stop_now, err_stop;

    assign t_clear = (state_q == ST_LAUNCH);
    assign t_en    = (state_q == ST_WAIT) ||
                     (state_q == ST_DRAIN);

    rd_seq_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (t_clear),
        .enable  (t_en),
        .limit   (tmo_q),
        .expired (t_exp)
    );

    assign eff_loop = (loop_q == 16'd0) ? 17'd1 : {1'b0, loop_q};
    assign iter_nx  = {1'b0, iter_q} + 17'd1;
    // True when the iteration finishing now is not the last one
    assign remain   = iter_nx < eff_loop;
    // A stop seen during LAUNCH is held in pend_q until WAIT
    assign stop_now = cfg_stop | pend_q;

    assign err_acc[ERR_RESP_BIT] = err_q[ERR_RESP_BIT] |
                                   rd_error[ERR_RESP_BIT];
    assign err_acc[ERR_DATA_BIT] = err_q[ERR_DATA_BIT] |
                                   rd_error[ERR_DATA_BIT];
    assign err_stop = (STOP_ON_ERROR != 0) && (err_acc != 2'b00);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        pat_d   = pat_q;
        num_d   = num_q;
        init_d  = init_q;
        wm_d    = wm_q;
        wl_d    = wl_q;
        loop_d  = loop_q;
        tmo_d   = tmo_q;
        iter_d  = iter_q;
        err_d   = err_q;
        info_d  = info_q;
        to_d    = to_q;
        ab_d    = ab_q;
        pend_d  = pend_q;
        cyc_d   = cyc_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    src_d   = cfg_source_address;
                    pat_d   = cfg_rd_pattern;
                    num_d   = cfg_rd_number;
                    init_d  = cfg_rd_init_data;
                    wm_d    = cfg_wrap_mode;
                    wl_d    = cfg_wrap_len;
                    loop_d  = cfg_loop_count;
                    tmo_d   = cfg_timeout;
                    iter_d  = 16'd0;
                    err_d   = 2'b00;
                    info_d  = 64'd0;
                    to_d    = 1'b0;
                    ab_d    = 1'b0;
                    pend_d  = 1'b0;
                    cyc_d   = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (num_q == 32'd0) begin
                    // Zero-length run: engine is never launched
                    iter_d = iter_nx[15:0];
                    if (!remain || stop_now) begin
                        ab_d    = stop_now && remain;
                        state_d = ST_DONE;
                    end
                end else begin
                    pend_d  = stop_now;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rd_done_pulse) begin
                    iter_d = iter_nx[15:0];
                    err_d  = err_acc;
                    if (rd_error != 2'b00 && err_q == 2'b00) begin
                        info_d = rd_error_info;
                    end
                    if (remain && !stop_now && !err_stop) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        ab_d    = stop_now && remain;
                        state_d = ST_DONE;
                    end
                end else if (t_exp) begin
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (stop_now) begin
                    ab_d    = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rd_done_pulse) begin
                    iter_d = iter_nx[15:0];
                    err_d  = err_acc;
                    if (rd_error != 2'b00 && err_q == 2'b00) begin
                        info_d = rd_error_info;
                    end
                    state_d = ST_DONE;
                end else if (t_exp) begin
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (busy && (cyc_q != '1)) begin
            cyc_d = cyc_q + CYC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= 64'd0;
            pat_q   <= 32'd0;
            num_q   <= 32'd0;
            init_q  <= 32'd0;
            wm_q    <= 1'b0;
            wl_q    <= 4'd0;
            loop_q  <= 16'd0;
            tmo_q   <= DEF_TIMEOUT;
            iter_q  <= 16'd0;
            err_q   <= 2'b00;
            info_q  <= 64'd0;
            to_q    <= 1'b0;
            ab_q    <= 1'b0;
            pend_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pat_q   <= pat_d;
            num_q   <= num_d;
            init_q  <= init_d;
            wm_q    <= wm_d;
            wl_q    <= wl_d;
            loop_q  <= loop_d;
            tmo_q   <= tmo_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
            info_q  <= info_d;
            to_q    <= to_d;
            ab_q    <= ab_d;
            pend_q  <= pend_d;
            cyc_q   <= cyc_d;
        end
    end

    assign busy = (state_q == ST_LAUNCH) ||
                  (state_q == ST_WAIT) ||
                  (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);
    assign engine_start_pulse = (state_q == ST_LAUNCH) &&
                                (num_q != 32'd0);

    assign source_address = src_q;
    assign rd_pattern     = pat_q;
    assign rd_number      = num_q;
    assign rd_init_data   = init_q;
    assign wrap_mode      = wm_q;
    assign wrap_len       = wl_q;
    assign sts_timeout    = to_q;
    assign sts_aborted    = ab_q;
    assign sts_error      = err_q;
    assign sts_err_info   = info_q;
    assign sts_iter       = iter_q;
    assign sts_cycles     = cyc_q;

endmodule
